// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// uart_rx_ctrl : UART receive controller.
// It synchronises the RX line, detects the start bit and samples each bit at
// mid-bit. It drives the SIPO shift strobe and assembles the received byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic                  tick,
  output logic                  rx_bit,
  output logic                  shift_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] c_HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] c_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] c_BLAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic [SW-1:0]         r_sample_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      rx_bit       <= 1'b0;
      shift_en     <= 1'b0;
      data_out     <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_s    <= r_rx_meta;
      shift_en  <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        case (r_state)
          S_IDLE: begin
            if (!r_rx_s) begin
              r_state      <= S_START;
              r_sample_cnt <= '0;
              busy         <= 1'b1;
            end
          end
          S_START: begin
            if (r_sample_cnt == c_HALF) begin
              r_sample_cnt <= '0;
              r_bit_cnt    <= '0;
              if (!r_rx_s) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (r_sample_cnt == c_LAST) begin
              r_shift      <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
              rx_bit       <= r_rx_s;
              shift_en     <= 1'b1;
              r_sample_cnt <= '0;
              if (r_bit_cnt == c_BLAST) begin
                r_state <= S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
          S_STOP: begin
            // Leaving at mid-stop gives half a bit of margin for the next start edge
            if (r_sample_cnt == c_LAST) begin
              r_sample_cnt <= '0;
              if (r_rx_s) begin
                data_out <= r_shift;
                rx_valid <= 1'b1;
                r_state  <= S_IDLE;
                busy     <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                r_state   <= S_BREAK;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
          S_BREAK: begin
            if (r_rx_s) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// tb_uart_rx_ctrl : scoreboard bench for uart_rx_ctrl with directed frames.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       tick = 1'b0;
  logic       rx_bit;
  logic       shift_en;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .tick      (tick),
    .rx_bit    (rx_bit),
    .shift_en  (shift_en),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // kind: 0 = shift strobe, 1 = good frame, 2 = framing error
  typedef struct {
    int         kind;
    logic [7:0] val;
    bit         first;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errs   = 0;
  int  cyc      = 0;
  int  tick_div = 1;
  int  shift_cnt = 0;
  int  last_shift_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    tick = ((cyc % tick_div) == 0);
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin
    ev_t e;
    int  n;
    int  kind;
    if (!reset && (shift_en || rx_valid || frame_err)) begin
      n = int'(shift_en) + int'(rx_valid) + int'(frame_err);
      check("event_exclusive", 32'(n), 32'd1);
      kind = shift_en ? 0 : (rx_valid ? 1 : 2);
      if (exp_q.size() == 0) begin
        check("unexpected_event_kind", 32'(kind), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        if (kind == 0 && e.kind == 0) begin
          check("rx_bit", 32'(rx_bit), 32'(e.val[0]));
          if (!e.first)
            check("shift_spacing", 32'(cyc - last_shift_cyc), 32'(16 * tick_div));
        end
        if (kind == 1 && e.kind == 1)
          check("data_out", 32'(data_out), 32'(e.val));
      end
      if (shift_en) begin
        shift_cnt++;
        last_shift_cyc = cyc;
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_clks(16 * tick_div);
  endtask

  task automatic expect_bits(input logic [7:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ev_t e;
      e.kind = 0; e.val = {7'd0, d[i]}; e.first = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    ev_t e;
    expect_bits(d, 8);
    e.kind = stop ? 1 : 2; e.val = d; e.first = 1'b0;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc0;
    logic [7:0] d;
    wait_clks(3);
    check("reset_shift_en", 32'(shift_en), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_clks(5);
    check("idle_data_out", 32'(data_out), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic frame, tick always high
    send_frame(8'hA5, 1'b1);
    wait_clks(4);
    check("a5_busy_after", 32'(busy), 32'd0);
    check("a5_data_out", 32'(data_out), 32'hA5);
    check("a5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start-bit glitch
    rx_in = 1'b0;
    wait_clks(4);
    check("glitch_busy_in_start", 32'(busy), 32'd1);
    rx_in = 1'b1;
    wait_clks(8);
    check("glitch_busy_cleared", 32'(busy), 32'd0);
    wait_clks(20);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0);
    wait_clks(40);
    check("break_busy_held", 32'(busy), 32'd1);
    rx_in = 1'b1;
    wait_clks(6);
    check("break_busy_cleared", 32'(busy), 32'd0);
    check("ferr_data_kept", 32'(data_out), 32'hA5);
    check("ferr_queue_empty", 32'(exp_q.size()), 32'd0);
    wait_clks(20);

    // Back-to-back frames
    sc0 = shift_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(4);
    check("b2b_shift_count", 32'(shift_cnt - sc0), 32'd16);
    check("b2b_data_out", 32'(data_out), 32'hFF);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    wait_clks(10);

    // Reset during bit 4 of 0x5A, then 0xC3
    d = 8'h5A;
    expect_bits(d, 4);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_in = d[4];
    wait_clks(4);
    reset = 1'b1;
    wait_clks(2);
    check("rst_rx_bit", 32'(rx_bit), 32'd0);
    check("rst_shift_en", 32'(shift_en), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rx_in = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(30);
    check("rst_no_pulse_queue", 32'(exp_q.size()), 32'd0);
    check("rst_data_still_zero", 32'(data_out), 32'd0);
    send_frame(8'hC3, 1'b1);
    wait_clks(4);
    check("c3_data_out", 32'(data_out), 32'hC3);
    check("c3_queue_empty", 32'(exp_q.size()), 32'd0);
    wait_clks(10);

    // Sparse tick: one tick every 4 clocks
    tick_div = 4;
    wait_clks(8);
    send_frame(8'h81, 1'b1);
    wait_clks(16);
    check("81_data_out", 32'(data_out), 32'h81);
    check("81_busy_after", 32'(busy), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller that sits directly upstream of the receive SIPO shift register. It synchronises the raw RX line and detects the start bit using an oversample tick from the baud generator. It samples each data bit at mid-bit and drives the SIPO's serial bit and shift-enable, one pulse per data bit. It also assembles its own LSB-first byte, checks the stop bit, and reports frame completion or framing error.

Parameters:
DATA_WIDTH, 8, data bits per frame (>=2)
OVERSAMPLE, 16, oversample ticks per bit period (even, >=4)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_in  input  1  raw asynchronous serial line, idle high
tick  input  1  oversample enable, 1-clk pulse, OVERSAMPLE pulses per bit
rx_bit  output  1  sampled data bit to SIPO serial_in
shift_en  output  1  1-clk strobe to SIPO shift_en, one per data bit
data_out  output  DATA_WIDTH  last good frame, LSB = first received bit
rx_valid  output  1  1-clk pulse: data_out updated with good frame
frame_err  output  1  1-clk pulse: stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock is clk; reset is asynchronous, active-high.
- Reset values: rx_bit=0, shift_en=0, data_out=0, rx_valid=0, frame_err=0, busy=0. State=IDLE, counters=0, synchroniser flops=1.
- rx_in passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- Counters and decisions advance only in clk cycles where tick=1. Outputs are registered.
- sample_cnt: 0..OVERSAMPLE-1. bit_cnt: 0..DATA_WIDTH-1. Both are internal.
- IDLE:
  - tick & rx_s=0 -> START, sample_cnt=0.
- START:
  - Each tick: sample_cnt++.
  - At tick with sample_cnt==OVERSAMPLE/2-1 (start-bit midpoint):
    - rx_s=0 -> DATA, sample_cnt=0, bit_cnt=0.
    - rx_s=1 -> false start (glitch) -> IDLE, no outputs.
- DATA:
  - Each tick: sample_cnt++.
  - At tick with sample_cnt==OVERSAMPLE-1 (mid-bit):
    - Shift rx_s into the internal register from MSB side, right shift.
    - Next clk: rx_bit=rx_s and shift_en=1 for exactly one clk. rx_bit holds its value until the next sample.
    - sample_cnt=0.
    - bit_cnt==DATA_WIDTH-1 -> STOP; else bit_cnt++.
- STOP:
  - At tick with sample_cnt==OVERSAMPLE-1:
    - rx_s=1 -> data_out=internal register, rx_valid pulse (1 clk), -> IDLE.
    - rx_s=0 -> frame_err pulse (1 clk), data_out unchanged, -> BREAK.
- BREAK:
  - Waits for a tick with rx_s=1, then -> IDLE.
  - Prevents a held-low line (break) from being taken as a new start.
- Because STOP exits at mid-stop-bit, the next start edge is detectable within half a bit, so back-to-back frames with one stop bit are supported.
- rx_valid and frame_err are never both high. shift_en is never high in the same clk as either.
- Reset mid-frame: immediately returns to IDLE with all reset values. A partial frame yields no rx_valid or frame_err.
- tick held high continuously is legal; one bit period is then OVERSAMPLE clks.
- Latency: rx_valid rises 1 clk after the mid-stop-bit tick. Start-edge recognition adds 2 clks of synchroniser delay.

Test Plan:
- OVERSAMPLE=16, tick=1 constant, frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) -> exactly 8 shift_en pulses, 16 clks apart, with rx_bit=1,0,1,0,0,1,0,1. Then one rx_valid pulse with data_out=0xA5, frame_err=0, busy low after.
- rx_in low for 4 clks then high (tick=1) -> START entered then aborted. No shift_en, rx_valid or frame_err. busy returns 0 within 8 clks.
- Frame 0x3C with stop bit driven 0 and line held low 40 clks -> frame_err single pulse, rx_valid=0, data_out keeps its previous value. busy stays 1 until the line returns high, then IDLE. No spurious frame.
- Back-to-back 0x00 then 0xFF, one stop bit each -> two rx_valid pulses with data_out=0x00 then 0xFF. 16 shift_en pulses total. No frame_err.
- Assert reset during bit 4 of 0x5A, release, send 0xC3 -> all outputs 0 during reset, no pulse for the aborted frame, then data_out=0xC3 with one rx_valid pulse.
- tick pulsed every 4th clk, frame 0x81 -> same results as the tick=1 case, with shift_en spacing of 64 clks.
